// File: rtl/tap_window_buffer_pkg.sv
// Types and helpers shared by the tap window buffer and its consumers.
package tap_window_buffer_pkg;

    `include "complex_adaptive_kalman_params.svh"

    typedef logic [TAP_BUS_W-1:0] tap_window_t;

    // LSB position of tap k of channel c inside a packed window bus.
    function automatic int tap_index(input int c, input int k,
                                     input int depth  = FILTER_LENGTH,
                                     input int data_w = FXP_WIDTH);
        return (c * depth + k) * data_w;
    endfunction

endpackage

// File: rtl/complex_adaptive_kalman_params.svh
// Shared sizing constants for the complex adaptive Kalman filter datapath.
`ifndef COMPLEX_ADAPTIVE_KALMAN_PARAMS_SVH
`define COMPLEX_ADAPTIVE_KALMAN_PARAMS_SVH

localparam int FXP_WIDTH     = 16;
localparam int FILTER_LENGTH = 8;
localparam int NUM_CH        = 2;
localparam int TAP_BUS_W     = NUM_CH * FILTER_LENGTH * FXP_WIDTH;

`endif

// File: rtl/tap_window_buffer_tap_shift_lane.sv
// One channel's tap delay line; tap 0 holds the newest sample.
module tap_shift_lane #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] taps_out
);

    logic [DATA_W-1:0] r_taps [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_taps[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) r_taps[k] <= '0;
        end else if (shift_en) begin
            r_taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) r_taps[k] <= r_taps[k-1];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap_out
            assign taps_out[gi*DATA_W +: DATA_W] = r_taps[gi];
        end
    endgenerate

endmodule

// File: rtl/tap_window_buffer.sv
// Multi-channel tap window buffer with ready/valid flow control and strided
// window emission once every tap holds accepted data.
module tap_window_buffer #(
    parameter int DATA_W   = tap_window_buffer_pkg::FXP_WIDTH,
    parameter int DEPTH    = tap_window_buffer_pkg::FILTER_LENGTH,
    parameter int NUM_CH   = tap_window_buffer_pkg::NUM_CH,
    parameter int STRIDE_W = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*DATA_W-1:0]       in_data,
    input  logic                           flush,
    input  logic [STRIDE_W-1:0]            cfg_stride,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*DEPTH*DATA_W-1:0] out_data,
    output logic                           primed
);

    import tap_window_buffer_pkg::*;

    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [FILL_W-1:0]   r_fill;
    logic [STRIDE_W-1:0] r_ph;
    logic [STRIDE_W-1:0] r_stride;
    logic                r_out_valid;

    logic w_acc;
    logic w_primed;
    logic w_priming;
    logic w_emit;

    assign in_ready  = !flush && (!r_out_valid || out_ready);
    assign w_acc     = in_valid && in_ready;
    assign w_primed  = (r_fill == FILL_W'(DEPTH));
    assign w_priming = w_acc && (r_fill == FILL_W'(DEPTH - 1));
    assign w_emit    = w_priming || (w_acc && w_primed && (r_ph == r_stride));

    assign out_valid = r_out_valid;
    assign primed    = w_primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill      <= '0;
            r_ph        <= '0;
            r_stride    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_fill      <= '0;
            r_ph        <= '0;
            r_stride    <= cfg_stride;
            r_out_valid <= 1'b0;
        end else begin
            if (w_acc && !w_primed) r_fill <= r_fill + FILL_W'(1);

            // Phase only advances on accepts after the window is full.
            if (w_priming) begin
                r_ph <= '0;
            end else if (w_acc && w_primed) begin
                r_ph <= (r_ph == r_stride) ? '0 : r_ph + STRIDE_W'(1);
            end

            if (w_emit) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            tap_shift_lane #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (flush),
                .shift_en (w_acc),
                .din      (in_data[gi*DATA_W +: DATA_W]),
                .taps_out (out_data[tap_index(gi, 0, DEPTH, DATA_W) +: DEPTH*DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tap_window_buffer.sv
// Directed bench for tap_window_buffer with a sample-history reference model.
module tb_tap_window_buffer;

    localparam int DW = 16;
    localparam int DP = 4;
    localparam int NC = 2;
    localparam int SW = 4;
    localparam int BUS_W = NC * DP * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NC*DW-1:0]  in_data = '0;
    logic              flush = 1'b0;
    logic [SW-1:0]     cfg_stride = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [BUS_W-1:0]  out_data;
    logic              primed;

    int n_cmp  = 0;
    int n_fail = 0;

    tap_window_buffer #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .NUM_CH   (NC),
        .STRIDE_W (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .cfg_stride (cfg_stride),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: history of accepted samples since flush, newest first.
    logic [DW-1:0] h0[$];
    logic [DW-1:0] h1[$];
    int n_acc    = 0;
    int m_stride = 1;
    int n_win    = 0;
    bit m_ov     = 1'b0;
    bit m_acc;
    bit m_emit;

    function automatic logic [BUS_W-1:0] model_bus();
        logic [BUS_W-1:0] b;
        b = '0;
        for (int k = 0; k < DP; k++) begin
            if (k < h0.size()) begin
                b[k*DW +: DW]      = h0[k];
                b[(DP+k)*DW +: DW] = h1[k];
            end
        end
        return b;
    endfunction

    always @(negedge rst_n) begin
        h0.delete();
        h1.delete();
        n_acc    = 0;
        m_stride = 1;
        m_ov     = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                h0.delete();
                h1.delete();
                n_acc    = 0;
                m_ov     = 1'b0;
                m_stride = int'(cfg_stride) + 1;
            end else begin
                m_acc  = in_valid && (!m_ov || out_ready);
                m_emit = 1'b0;
                if (m_acc) begin
                    h0.push_front(in_data[DW-1:0]);
                    h1.push_front(in_data[2*DW-1:DW]);
                    if (h0.size() > DP) begin
                        void'(h0.pop_back());
                        void'(h1.pop_back());
                    end
                    n_acc++;
                    m_emit = (n_acc >= DP) && (((n_acc - DP) % m_stride) == 0);
                end
                if (m_emit) begin
                    m_ov = 1'b1;
                    n_win++;
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_in_ready", BUS_W'(in_ready), BUS_W'(!flush && (!m_ov || out_ready)));
            chk("model_out_valid", BUS_W'(out_valid), BUS_W'(m_ov));
            chk("model_primed", BUS_W'(primed), BUS_W'(n_acc >= DP));
            chk("model_out_data", out_data, model_bus());
        end
    end

    // Drive one vector (ch0 = v, ch1 = -v) for one cycle; report ready and valid after the edge.
    task automatic send(input int v, output bit rdy, output bit ov);
        in_valid = 1'b1;
        in_data  = {DW'(-v), DW'(v)};
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
        ov = out_valid;
        $display("txn sample=%0d in_ready=%0b out_valid=%0b primed=%0b", v, rdy, ov, primed);
    endtask

    task automatic do_flush(input int stride_m1);
        in_valid   = 1'b0;
        flush      = 1'b1;
        cfg_stride = SW'(stride_m1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        $display("txn flush cfg_stride=%0d", stride_m1);
    endtask

    localparam logic [BUS_W-1:0] WIN_1_4 =
        {16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'd1, 16'd2, 16'd3, 16'd4};
    localparam logic [BUS_W-1:0] WIN_7_10 =
        {16'hFFF9, 16'hFFF8, 16'hFFF7, 16'hFFF6, 16'd7, 16'd8, 16'd9, 16'd10};
    localparam logic [BUS_W-1:0] WIN_50 =
        {16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFCE, 16'd2, 16'd3, 16'd4, 16'd50};

    initial begin
        bit rdy, ov;
        int wins, win0;
        logic [12:0] mask;

        // Reset state
        #2;
        chk("rst_out_valid", BUS_W'(out_valid), '0);
        chk("rst_primed", BUS_W'(primed), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", BUS_W'(in_ready), BUS_W'(1));
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Priming
        for (int i = 1; i <= 4; i++) begin
            send(i, rdy, ov);
            chk("prime_out_valid", BUS_W'(ov), BUS_W'(i == 4));
        end
        chk("prime_primed", BUS_W'(primed), BUS_W'(1));
        chk("prime_window", out_data, WIN_1_4);

        // Stride 1 continuous stream
        do_flush(0);
        wins = 0;
        win0 = n_win;
        for (int i = 1; i <= 10; i++) begin
            send(i, rdy, ov);
            chk("stream_in_ready", BUS_W'(rdy), BUS_W'(1));
            if (ov) wins++;
        end
        chk("stream_windows", BUS_W'(wins), BUS_W'(7));
        chk("stream_model_windows", BUS_W'(n_win - win0), BUS_W'(7));
        chk("stream_last_window", out_data, WIN_7_10);

        // Stride 3
        do_flush(2);
        mask = '0;
        for (int i = 1; i <= 13; i++) begin
            send(i, rdy, ov);
            mask[i-1] = ov;
        end
        chk("stride3_emit_mask", BUS_W'(mask), BUS_W'(13'h1248));

        // Backpressure
        do_flush(0);
        for (int i = 1; i <= 4; i++) send(i, rdy, ov);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {DW'(-(100 + i)), DW'(100 + i)};
            #1;
            chk("bp_in_ready", BUS_W'(in_ready), '0);
            chk("bp_out_data", out_data, WIN_1_4);
            chk("bp_out_valid", BUS_W'(out_valid), BUS_W'(1));
            $display("txn stalled sample=%0d in_ready=%0b", 100 + i, in_ready);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(50, rdy, ov);
        chk("bp_release_valid", BUS_W'(ov), BUS_W'(1));
        chk("bp_release_window", out_data, WIN_50);

        // Flush with a pending window
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        flush      = 1'b1;
        cfg_stride = '0;
        #1;
        chk("flush_in_ready", BUS_W'(in_ready), '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        $display("txn flush with pending window");
        chk("flush_out_valid", BUS_W'(out_valid), '0);
        chk("flush_primed", BUS_W'(primed), '0);
        chk("flush_out_data", out_data, '0);
        out_ready = 1'b1;

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 5; i++) send(i, rdy, ov);
        in_valid = 1'b1;
        in_data  = {DW'(-6), DW'(6)};
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", BUS_W'(out_valid), '0);
        chk("arst_primed", BUS_W'(primed), '0);
        chk("arst_out_data", out_data, '0);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("arst_in_ready", BUS_W'(in_ready), BUS_W'(1));
        $display("txn async reset released");
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
